mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit sitting between the register file's read ports and its write port. It takes the two source operands read from the register file plus the destination register address, runs a 32-step shift/add or shift/subtract sequence, and presents a one-cycle write-back request (data, address, enable) that drives the register file's `WD3`/`A3`/`WE3`. The core stalls on `Busy` while an operation is in flight.

## Interface
- `DATA_WIDTH`, 32, operand/result width; only 32 is supported.
- `ADDRESS_WIDTH`, 5, register address width.
- `CLK` input 1: the single clock; all state updates on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `Start` input 1: request a new operation; sampled only in IDLE.
- `Funct3` input 3: RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA` input DATA_WIDTH: rs1 value (multiplicand/dividend).
- `SrcB` input DATA_WIDTH: rs2 value (multiplier/divisor).
- `RdIn` input ADDRESS_WIDTH: destination register.
- `Busy` output 1: operation accepted and not yet complete (high in CALC and DONE).
- `Done` output 1: one-cycle result-valid pulse.
- `Result` output DATA_WIDTH: result; held stable from DONE until the next accept.
- `RdOut` output ADDRESS_WIDTH: latched `RdIn`.
- `WE` output 1: `Done && RdOut != 0`; register x0 is never written.
- `Illegal` output 1: pulses with `Done` for a disabled op (see Configuration); otherwise 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `Start`, latch `Funct3`, `RdIn`, |SrcA|, |SrcB| (absolute value per op signedness), and the result-sign flag. Load the step counter with 31 and go to CALC. The special-case ops below go straight to DONE.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When the counter reaches 0, go to DONE.
- Sign fix on entry to DONE:
  - MUL/MULH: negate the 64-bit product if the operand signs differ.
  - MULHSU: only SrcA is treated as signed.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the sign of the dividend.
- Result selection: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32]; DIV/DIVU give the quotient; REM/REMU give the remainder.
- Special cases (resolved in IDLE, no iterations):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- DONE: assert `Done` for one cycle, then return to IDLE.
- `Start` is ignored while `Busy`; there is no queueing.
- `RST` at any time, including mid-CALC: next state IDLE, and `Busy`, `Done`, `WE`, `Illegal`, `Result`, `RdOut` all become 0. The in-flight operation is discarded.

## Timing
- Reset values: every output is 0.
- Normal op: `Start` sampled at edge E0. `Busy` is high from after E0. CALC spans E1–E32 (32 iterations). `Done`/`WE` are high in the cycle after E32, i.e. 33 cycles after `Start` is accepted. `Busy` drops with `Done` at the following edge.
- Special-case op: `Done` is high in the cycle immediately after E0 (latency 1).
- Back-to-back: a `Start` held high during the DONE cycle is not accepted. It is accepted at the first IDLE edge, so the minimum issue interval is 34 cycles for normal ops.

## Configuration
- `MUL_DIV_DIVIDE_EN` defined: all eight ops are implemented as above, and `Illegal` is tied 0.
- `MUL_DIV_DIVIDE_EN` undefined:
  - The divide datapath is removed.
  - Funct3[2]=1 ops take the 1-cycle path with `Result`=0, `Illegal`=1 and `Done`=1 but `WE`=0.
  - Multiply ops are unchanged.

## Structure
- `mul_div_pkg` holds:
  - the Funct3 op enum;
  - the state enum (IDLE/CALC/DONE);
  - `MD_ITERS`=32;
  - constants `DIV0_QUOT`=32'hFFFFFFFF and `INT_MIN`=32'h80000000.
- One sub-module, `mul_div_core`: the unsigned 32-step iterative shift/add–subtract datapath plus the step counter. The top level handles sign conditioning, special cases, the FSM and write-back outputs.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD (-3), RdIn=5 -> `Done`/`WE` 33 cycles after accept, `Result`=0xFFFFFFEB, `RdOut`=5; `Busy` high throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with latency 1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with latency 1.
- Assert `RST` in CALC cycle 10 -> all outputs 0 the next cycle. A new MUL 3×4 then gives 12 with no residue from the aborted op.
- RdIn=0 MUL 2×3 -> `Done`=1, `Result`=6, `WE`=0. A `Start` pulsed mid-CALC is ignored, with exactly one `Done` observed.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int MD_ITERS = 32;
  localparam int CNT_W    = $clog2(MD_ITERS);

  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;

endpackage

// File: rtl/mul_div_core.sv
// Unsigned 32-step shift/add multiplier and restoring divider with step counter.
// The divide datapath exists only when MUL_DIV_DIVIDE_EN is defined.
module mul_div_core
  import mul_div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         i_load,
`ifdef MUL_DIV_DIVIDE_EN
  input  logic         i_is_div,
`endif
  input  logic [W-1:0] i_lo_init,
  input  logic [W-1:0] i_opnd,
  output logic         o_last,
  output logic [W-1:0] o_hi_next,
  output logic [W-1:0] o_lo_next
);

  // hi/lo hold {product high, multiplier} for multiply, {remainder, quotient} for divide
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [W:0]       w_add;
`ifdef MUL_DIV_DIVIDE_EN
  logic             r_is_div;
  logic [W:0]       w_shift;
  logic [W-1:0]     w_sub;
  logic             w_ge;
`endif

  always_comb begin
    w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    o_hi_next = w_add[W:1];
    o_lo_next = {w_add[0], r_lo[W-1:1]};
`ifdef MUL_DIV_DIVIDE_EN
    w_shift = {r_hi, r_lo[W-1]};
    w_ge    = (w_shift >= {1'b0, r_opnd});
    // Partial remainder after a successful subtract is below the divisor, so W bits suffice
    w_sub   = w_shift[W-1:0] - r_opnd;
    if (r_is_div) begin
      o_hi_next = w_ge ? w_sub : w_shift[W-1:0];
      o_lo_next = {r_lo[W-2:0], w_ge};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
`ifdef MUL_DIV_DIVIDE_EN
      r_is_div <= 1'b0;
`endif
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_lo_init;
      r_opnd <= i_opnd;
      r_cnt  <= CNT_W'(MD_ITERS - 1);
      r_run  <= 1'b1;
`ifdef MUL_DIV_DIVIDE_EN
      r_is_div <= i_is_div;
`endif
    end else if (r_run) begin
      r_hi  <= o_hi_next;
      r_lo  <= o_lo_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_run <= 1'b0;
    end
  end

  assign o_last = r_run && (r_cnt == '0);

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: sign conditioning, special cases, FSM and write-back.
// Define MUL_DIV_DIVIDE_EN to enable DIV/DIVU/REM/REMU; otherwise they report Illegal.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [2:0]               Funct3,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [ADDRESS_WIDTH-1:0] RdIn,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic [ADDRESS_WIDTH-1:0] RdOut,
  output logic                     WE,
  output logic                     Illegal
);

  state_e                   r_state;
  state_e                   w_state_next;
  op_e                      r_op;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic                     r_neg;
  logic                     r_illegal;
  logic [DATA_WIDTH-1:0]    r_result;

  op_e                      w_op;
  logic                     w_accept;
  logic                     w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic [DATA_WIDTH-1:0]    w_a_abs, w_b_abs;
  logic                     w_special, w_illegal_op;
  logic [DATA_WIDTH-1:0]    w_special_res;
  logic                     w_last;
  logic [DATA_WIDTH-1:0]    w_hi_next, w_lo_next;
  logic [2*DATA_WIDTH-1:0]  w_prod;
  logic [DATA_WIDTH-1:0]    w_fixed_res;

  assign w_op     = op_e'(Funct3);
  assign w_accept = (r_state == ST_IDLE) && Start;

  // MUL shares the signed path: its low word is sign-agnostic
  always_comb begin
    w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                 (w_op == OP_DIV) || (w_op == OP_REM);
    w_b_signed = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                 (w_op == OP_DIV) || (w_op == OP_REM);
    w_a_neg    = w_a_signed && SrcA[DATA_WIDTH-1];
    w_b_neg    = w_b_signed && SrcB[DATA_WIDTH-1];
    w_a_abs    = w_a_neg ? (~SrcA + 1'b1) : SrcA;
    w_b_abs    = w_b_neg ? (~SrcB + 1'b1) : SrcB;
    w_neg      = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  always_comb begin
`ifdef MUL_DIV_DIVIDE_EN
    w_illegal_op  = 1'b0;
    w_special     = 1'b0;
    w_special_res = '0;
    if (Funct3[2] && (SrcB == '0)) begin
      w_special     = 1'b1;
      w_special_res = Funct3[1] ? SrcA : DIV0_QUOT;
    end else if (((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (SrcA == INT_MIN) && (SrcB == '1)) begin
      w_special     = 1'b1;
      w_special_res = Funct3[1] ? '0 : INT_MIN;
    end
`else
    w_illegal_op  = Funct3[2];
    w_special     = Funct3[2];
    w_special_res = '0;
`endif
  end

  mul_div_core #(.W(DATA_WIDTH)) u_core (
    .clk       (CLK),
    .srst      (RST),
    .i_load    (w_accept && !w_special),
`ifdef MUL_DIV_DIVIDE_EN
    .i_is_div  (Funct3[2]),
    .i_lo_init (Funct3[2] ? w_a_abs : w_b_abs),
    .i_opnd    (Funct3[2] ? w_b_abs : w_a_abs),
`else
    .i_lo_init (w_b_abs),
    .i_opnd    (w_a_abs),
`endif
    .o_last    (w_last),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  // Sign fix applied to the value the last iteration is about to produce
  always_comb begin
    w_prod      = {w_hi_next, w_lo_next};
    if (r_neg) w_prod = ~w_prod + 1'b1;
    w_fixed_res = (r_op == OP_MUL) ? w_prod[DATA_WIDTH-1:0] : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MUL_DIV_DIVIDE_EN
    if (r_op == OP_DIV || r_op == OP_DIVU)
      w_fixed_res = r_neg ? (~w_lo_next + 1'b1) : w_lo_next;
    else if (r_op == OP_REM || r_op == OP_REMU)
      w_fixed_res = r_neg ? (~w_hi_next + 1'b1) : w_hi_next;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_next = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op      <= OP_MUL;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_rd      <= RdIn;
      r_neg     <= w_neg;
      r_illegal <= w_illegal_op;
      if (w_special) r_result <= w_special_res;
    end else if ((r_state == ST_CALC) && w_last) begin
      r_result <= w_fixed_res;
    end
  end

  always_comb begin
    Busy    = (r_state != ST_IDLE);
    Done    = (r_state == ST_DONE);
    Result  = r_result;
    RdOut   = r_rd;
    WE      = Done && (r_rd != '0) && !r_illegal;
    Illegal = Done && r_illegal;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences, random ops.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [4:0]  RdIn = '0;
  logic        Busy, Done, WE, Illegal;
  logic [31:0] Result;
  logic [4:0]  RdOut;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .RdIn(RdIn), .Busy(Busy), .Done(Done), .Result(Result), .RdOut(RdOut),
    .WE(WE), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural reference from the ISA definition using wide plain arithmetic
  function automatic void ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output int lat, output logic ill);
    longint sa, sb, ub, p;
    longint unsigned up;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    res = '0; lat = 33; ill = 1'b0;
    case (f)
      3'd0: begin p = sa * sb; res = p[31:0]; end
      3'd1: begin p = sa * sb; res = p[63:32]; end
      3'd2: begin p = sa * ub; res = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; res = up[63:32]; end
      3'd4: if (b == 0) begin res = 32'hFFFFFFFF; lat = 1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = a; lat = 1; end
            else res = 32'(ia / ib);
      3'd5: if (b == 0) begin res = 32'hFFFFFFFF; lat = 1; end else res = a / b;
      3'd6: if (b == 0) begin res = a; lat = 1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = 0; lat = 1; end
            else res = 32'(ia % ib);
      default: if (b == 0) begin res = a; lat = 1; end else res = a % b;
    endcase
`ifndef MUL_DIV_DIVIDE_EN
    if (f[2]) begin res = '0; lat = 1; ill = 1'b1; end
`endif
  endfunction

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_ill);
    int   lat;
    logic seen, busy_ok;
    @(negedge CLK);
    Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b; RdIn = rd;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) Start = 1'b0;
      if (Done) seen = 1'b1;
      else if (!Busy) busy_ok = 1'b0;
    end
    $display("op %s f=%0d a=%h b=%h rd=%0d -> result=%h latency=%0d we=%0b illegal=%0b",
             nm, f, a, b, rd, Result, lat, WE, Illegal);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " result"}, Result, exp_res);
    chk({nm, " we"}, 32'(WE), 32'((rd != 0) && !exp_ill));
    chk({nm, " illegal"}, 32'(Illegal), 32'(exp_ill));
    chk({nm, " rdout"}, 32'(RdOut), 32'(rd));
    chk({nm, " busy held"}, 32'(busy_ok), 32'd1);
    @(posedge CLK); #1;
    chk({nm, " idle after done"}, 32'({Busy, Done}), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, 32'(Busy), 32'd0);
    chk({nm, " done"}, 32'(Done), 32'd0);
    chk({nm, " we"}, 32'(WE), 32'd0);
    chk({nm, " illegal"}, 32'(Illegal), 32'd0);
    chk({nm, " result"}, Result, 32'd0);
    chk({nm, " rdout"}, 32'(RdOut), 32'd0);
  endtask

  initial begin
    logic [31:0] eres, r;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        eill;
    int          elat, dones;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       33};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        33};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        5'd14, 32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};
    vecs[12] = '{3'd0, 32'd2,        32'd3,        5'd0,  32'd6,        33};

    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    @(negedge CLK); RST = 1'b0;

    foreach (vecs[i]) begin
      eres = vecs[i].res; elat = vecs[i].lat; eill = 1'b0;
`ifndef MUL_DIV_DIVIDE_EN
      if (vecs[i].f[2]) begin eres = '0; elat = 1; eill = 1'b1; end
`endif
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, eres, elat, eill);
    end

    // Abort a multiply in CALC cycle 10 with reset
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'h12345678; SrcB = 32'h9ABCDEF0; RdIn = 5'd7;
    @(posedge CLK); #1; Start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    $display("op reset-abort busy=%0b result=%h rdout=%0d", Busy, Result, RdOut);
    chk_all_zero("midcalc reset");
    @(negedge CLK); RST = 1'b0;
    do_op("post-reset mul", 3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 33, 1'b0);

    // Start pulsed mid-CALC must be ignored
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6; RdIn = 5'd3;
    @(posedge CLK); #1; Start = 1'b0;
    dones = 0; r = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      Start = (i == 10); Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd0;
      @(posedge CLK); #1;
      if (Done) begin dones++; r = Result; end
    end
    Start = 1'b0;
    $display("op ignored-start dones=%0d result=%h", dones, r);
    chk("ignored start done count", 32'(dones), 32'd1);
    chk("ignored start result", r, 32'd30);

    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      ref_model(f, a, b, eres, elat, eill);
      do_op($sformatf("rand%0d", n), f, a, b, rd, eres, elat, eill);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
